cfg_shift_reg: RTL and testbench
================================

CFG_SHIFT_REG -- requirements
Module: cfg_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, number of register bits; legal range 2..1024.
REQ-002 Parameter RESET_VAL, default all-zeros (WIDTH bits), value loaded into Q by reset.
REQ-003 CK  input  1  clock; all state updates on rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SET  input  1  synchronous set, all bits to 1.
REQ-006 WE  input  1  parallel write enable.
REQ-007 BE  input  WIDTH  per-bit write mask, qualifies WE.
REQ-008 D  input  WIDTH  parallel data.
REQ-009 SE  input  1  shift (scan) enable.
REQ-010 SI  input  1  serial data in.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 SO  output  1  serial data out, equals Q[WIDTH-1] combinationally.
REQ-013 DONE  output  1  one-cycle pulse marking WIDTH completed shifts.

Function
REQ-014 Mode priority per edge SHALL be SET > WE > SE > HOLD.
REQ-015 SET=1: Q <= all ones; shift counter <= 0; DONE <= 0.
REQ-016 WE=1 (SET=0): for each bit i, Q[i] <= D[i] if BE[i]=1, else unchanged; shift counter <= 0; DONE <= 0.
REQ-017 WE=1 with BE all zeros SHALL leave Q unchanged but still clear the shift counter.
REQ-018 SE=1 (SET=0, WE=0): Q <= {Q[WIDTH-2:0], SI}; shift counter increments by 1.
REQ-019 Shift counter width SHALL be clog2(WIDTH+1) bits, unsigned.
REQ-020 When a shift edge takes the counter from WIDTH-1 to WIDTH, the counter SHALL instead wrap to 0 and DONE SHALL be 1 for exactly the following cycle.
REQ-021 Back-to-back full frames (SE held for 2*WIDTH cycles) SHALL produce two DONE pulses exactly WIDTH cycles apart.
REQ-022 HOLD (all of SET, WE, SE low): Q and shift counter unchanged; DONE <= 0.
REQ-023 SE deasserted mid-frame SHALL freeze the counter; shifting resumes counting from the frozen value when SE returns.
REQ-024 SO SHALL reflect Q[WIDTH-1] with zero latency, so SI shifted in appears on SO after exactly WIDTH shift edges.
REQ-025 Q SHALL be updated with single-cycle latency from any qualifying input; no combinational path from D, SI, WE, BE, SE or SET to Q.

Reset
REQ-026 RSTN=0 SHALL immediately, independent of CK, force Q to RESET_VAL, the shift counter to 0 and DONE to 0.
REQ-027 While RSTN=0, all other inputs SHALL be ignored.
REQ-028 Reset asserted mid-shift-frame SHALL abort the frame; no DONE pulse follows release.
REQ-029 First active edge after RSTN rises SHALL obey REQ-014 normally.

Structure
REQ-030 Shared package cfg_reg_pkg SHALL hold the mode enum (MODE_HOLD, MODE_SET, MODE_LOAD, MODE_SHIFT) and the counter-width function.
REQ-031 Mode decode SHALL be a single priority encoder producing the package enum.
REQ-032 Shift counter and DONE generation SHALL live in sub-module cfg_shift_cnt (params WIDTH; ports CK, RSTN, clr, inc, done).
REQ-033 Data path (Q, masked load, shift) SHALL remain in cfg_shift_reg.

Verification (WIDTH=8, RESET_VAL=8'hA5)
REQ-034 RSTN low between edges -> Q=8'hA5, SO=1, DONE=0 immediately; SET/WE/SE toggling while low has no effect.
REQ-035 Q=8'h00, WE=1, BE=8'h0F, D=8'hFF, one edge -> Q=8'h0F; then SET=1 and WE=1 same edge -> Q=8'hFF.
REQ-036 From reset, SE=1, SI pattern 1,0,1,1,0,0,1,0 over 8 edges -> Q=8'hB2, DONE high only in the cycle after the 8th edge.
REQ-037 SE=1 for 3 edges, SE=0 for 5 cycles, SE=1 for 5 edges -> single DONE after the 8th shift edge, none earlier.
REQ-038 SE=1 for 4 edges, then WE=1 with BE=0 one edge, then SE=1 for 8 edges -> DONE only after those final 8 shift edges.
REQ-039 SE=1 for 5 edges, RSTN pulsed low, then SE=1 for 3 edges -> no DONE; Q lower 3 bits hold the shifted SI values, upper bits from 8'hA5 shifted.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared types and helpers for the configuration shift register.
// Holds the mode encoding and the counter width function.
package cfg_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD,
    MODE_SET,
    MODE_LOAD,
    MODE_SHIFT
  } mode_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cfg_shift_cnt.sv
// Shift frame counter; pulses done for one cycle
// after every WIDTH counted shifts.
module cfg_shift_cnt
  import cfg_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic CK,
  input  logic RSTN,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;
  logic          r_done;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (inc) begin
      // The frame end wraps straight to 0 instead of reaching WIDTH
      if (r_cnt == LAST) begin
        r_cnt  <= '0;
        r_done <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done = r_done;

endmodule

// File: rtl/cfg_shift_reg.sv
// Configuration register with set, masked parallel load
// and scan shift; shift framing lives in cfg_shift_cnt.
module cfg_shift_reg
  import cfg_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             SET,
  input  logic             WE,
  input  logic [WIDTH-1:0] BE,
  input  logic [WIDTH-1:0] D,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             DONE
);

  mode_e            w_mode;
  logic             w_clr;
  logic             w_inc;
  logic [WIDTH-1:0] r_q;

  always_comb begin
    w_mode = MODE_HOLD;
    unique case (1'b1)
      SET:                w_mode = MODE_SET;
      !SET && WE:         w_mode = MODE_LOAD;
      !SET && !WE && SE:  w_mode = MODE_SHIFT;
      default:            w_mode = MODE_HOLD;
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_q <= RESET_VAL;
    end else begin
      unique case (w_mode)
        MODE_SET:   r_q <= '1;
        MODE_LOAD:  r_q <= (r_q & ~BE) | (D & BE);
        MODE_SHIFT: r_q <= {r_q[WIDTH-2:0], SI};
        default:    r_q <= r_q;
      endcase
    end
  end

  assign w_clr = (w_mode == MODE_SET) ||
                 (w_mode == MODE_LOAD);
  assign w_inc = (w_mode == MODE_SHIFT);

  cfg_shift_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .CK  (CK),
    .RSTN(RSTN),
    .clr (w_clr),
    .inc (w_inc),
    .done(DONE)
  );

  assign Q  = r_q;
  assign SO = r_q[WIDTH-1];

endmodule

// File: tb/tb_cfg_shift_reg.sv
// Directed bench for cfg_shift_reg at WIDTH=8,
// RESET_VAL=8'hA5.
module tb_cfg_shift_reg;

  logic       CK;
  logic       RSTN;
  logic       SET;
  logic       WE;
  logic [7:0] BE;
  logic [7:0] D;
  logic       SE;
  logic       SI;
  logic [7:0] Q;
  logic       SO;
  logic       DONE;

  int nchk;
  int nerr;

  typedef struct {
    logic       set;
    logic       we;
    logic [7:0] be;
    logic [7:0] d;
    logic       se;
    logic       si;
    logic [7:0] q;
    logic       done;
  } vec_t;

  vec_t vec [10];

  cfg_shift_reg #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) dut (
    .CK  (CK),
    .RSTN(RSTN),
    .SET (SET),
    .WE  (WE),
    .BE  (BE),
    .D   (D),
    .SE  (SE),
    .SI  (SI),
    .Q   (Q),
    .SO  (SO),
    .DONE(DONE)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drv(input logic set, input logic we,
                     input logic [7:0] be,
                     input logic [7:0] d,
                     input logic se, input logic si);
    SET = set;
    WE  = we;
    BE  = be;
    D   = d;
    SE  = se;
    SI  = si;
  endtask

  task automatic tick(input logic set, input logic we,
                      input logic [7:0] be,
                      input logic [7:0] d,
                      input logic se, input logic si);
    drv(set, we, be, d, se, si);
    @(posedge CK);
    #1;
  endtask

  task automatic rst_pulse();
    drv(0, 0, 8'h00, 8'h00, 0, 0);
    #2;
    RSTN = 1'b0;
    #1;
    chk("rst_q", Q, 8'hA5);
    chk("rst_done", {7'd0, DONE}, 8'd0);
    @(posedge CK);
    #1;
    RSTN = 1'b1;
  endtask

  logic [7:0] pat;

  initial begin
    nchk = 0;
    nerr = 0;
    pat  = 8'b1011_0010;
    RSTN = 1'b0;
    drv(0, 0, 8'h00, 8'h00, 0, 0);
    @(posedge CK);
    #1;
    chk("por_q", Q, 8'hA5);
    chk("por_so", {7'd0, SO}, 8'd1);
    chk("por_done", {7'd0, DONE}, 8'd0);
    RSTN = 1'b1;

    vec[0] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'hA5, 0};
    vec[1] = '{0, 1, 8'hFF, 8'h00, 0, 0, 8'h00, 0};
    vec[2] = '{0, 1, 8'h0F, 8'hFF, 0, 0, 8'h0F, 0};
    vec[3] = '{1, 1, 8'hFF, 8'h00, 0, 0, 8'hFF, 0};
    vec[4] = '{0, 1, 8'h00, 8'h00, 1, 0, 8'hFF, 0};
    vec[5] = '{0, 1, 8'hF0, 8'h3C, 0, 0, 8'h3F, 0};
    vec[6] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h7F, 0};
    vec[7] = '{0, 0, 8'hFF, 8'hFF, 0, 1, 8'h7F, 0};
    vec[8] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'hFE, 0};
    vec[9] = '{1, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 0};

    for (int i = 0; i < 10; i++) begin
      tick(vec[i].set, vec[i].we, vec[i].be,
           vec[i].d, vec[i].se, vec[i].si);
      chk($sformatf("vec%0d_q", i), Q, vec[i].q);
      chk($sformatf("vec%0d_so", i),
          {7'd0, SO}, {7'd0, vec[i].q[7]});
      chk($sformatf("vec%0d_done", i),
          {7'd0, DONE}, {7'd0, vec[i].done});
    end

    // Async reset between edges, inputs ignored while low
    #2;
    RSTN = 1'b0;
    #1;
    chk("arst_q", Q, 8'hA5);
    chk("arst_so", {7'd0, SO}, 8'd1);
    chk("arst_done", {7'd0, DONE}, 8'd0);
    tick(1, 0, 8'h00, 8'h00, 0, 0);
    tick(0, 1, 8'hFF, 8'h00, 0, 0);
    tick(0, 0, 8'h00, 8'h00, 1, 1);
    chk("arst_hold_q", Q, 8'hA5);
    drv(0, 0, 8'h00, 8'h00, 0, 0);
    RSTN = 1'b1;

    // Two back-to-back frames
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 8'h00, 8'h00, 1, pat[7 - (i % 8)]);
      chk($sformatf("b2b%0d_done", i), {7'd0, DONE},
          {7'd0, (i == 7 || i == 15)});
      if (i == 7 || i == 15) begin
        chk($sformatf("b2b%0d_q", i), Q, 8'hB2);
        chk($sformatf("b2b%0d_so", i), {7'd0, SO}, 8'd1);
      end
    end
    tick(0, 0, 8'h00, 8'h00, 0, 0);
    chk("b2b_after_done", {7'd0, DONE}, 8'd0);

    // Frozen counter across a shift gap
    tick(0, 1, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 13; i++) begin
      tick(0, 0, 8'h00, 8'h00, (i < 3 || i >= 8), 0);
      chk($sformatf("gap%0d_done", i), {7'd0, DONE},
          {7'd0, (i == 12)});
    end
    chk("gap_q", Q, 8'h00);
    tick(0, 0, 8'h00, 8'h00, 0, 0);
    chk("gap_after_done", {7'd0, DONE}, 8'd0);

    // Empty-mask write still restarts the frame
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 8'h00, 8'h00, 1, 1);
      chk($sformatf("clr_a%0d_done", i),
          {7'd0, DONE}, 8'd0);
    end
    tick(0, 1, 8'h00, 8'hA0, 1, 0);
    chk("clr_we_q", Q, 8'h0F);
    chk("clr_we_done", {7'd0, DONE}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 8'h00, 8'h00, 1, 1);
      chk($sformatf("clr_b%0d_done", i), {7'd0, DONE},
          {7'd0, (i == 7)});
    end
    chk("clr_q", Q, 8'hFF);

    // Reset mid-frame aborts it
    rst_pulse();
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 8'h00, 8'h00, 1, 1);
      chk($sformatf("ab_a%0d_done", i),
          {7'd0, DONE}, 8'd0);
    end
    chk("ab_mid_q", Q, 8'hBF);
    rst_pulse();
    pat = 8'b0000_0110;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 8'h00, 8'h00, 1, pat[2 - i]);
      chk($sformatf("ab_b%0d_done", i),
          {7'd0, DONE}, 8'd0);
    end
    chk("ab_q", Q, 8'h2E);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 8'h00, 8'h00, 0, 0);
      chk($sformatf("ab_h%0d_done", i),
          {7'd0, DONE}, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
